// File: rtl/hf_array_pkg.sv
// hf_array_pkg: shared lane width, default sizing and FSM encoding for the array feed path
package hf_array_pkg;
  localparam int LANE_W = 8;
  localparam int N_DEFAULT = 4;
  localparam int BEATS_DEFAULT = 7;
  localparam int TIMEOUT_DEFAULT = 15;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} feed_state_e;
endpackage

// File: rtl/array_feed_skid.sv
// array_feed_skid: 2-entry FIFO holding {last, data} beats captured one cycle after each lane read
module array_feed_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic wr_q, wr_d, rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    mem_d[wr_q] = push ? push_data : mem_q[wr_q];
    wr_d = wr_q ^ push;
    rd_d = rd_q ^ pop;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    head = mem_q[rd_q];
    count = cnt_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      mem_q <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/array_feed_scheduler.sv
// array_feed_scheduler: reads N lane FIFOs in lock-step and feeds BEATS-beat bursts to the array row.
// Defining ARRAY_FEED_PERF_EN adds stall/starve/burst performance counters.
module array_feed_scheduler
  import hf_array_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int BEATS = BEATS_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [N-1:0]        lane_empty,
  input  logic [LANE_W*N-1:0] lane_data,
  output logic                global_re,
  output logic [LANE_W*N-1:0] feed_data,
  output logic                feed_valid,
  output logic                feed_last,
  input  logic                feed_ready,
  output logic                busy,
  output logic                desync_err
`ifdef ARRAY_FEED_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         starve_cycles,
  output logic [15:0]         burst_count
`endif
);
  localparam int W = LANE_W * N + 1;
  localparam int DW = $clog2(TIMEOUT + 1);
  feed_state_e state_q, state_d;
  logic [2:0] beat_q, beat_d;
  logic inflight_q, inflight_d, last_pend_q, last_pend_d, err_q, err_d;
  logic [DW-1:0] desync_q, desync_d;
  logic [W-1:0] head;
  logic [1:0] skid_cnt;
  logic lanes_ready, lanes_mixed, pop, last_rd, drained;
  array_feed_skid #(.W(W)) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .push      (inflight_q),
    .push_data ({last_pend_q, lane_data}),
    .pop       (pop),
    .head      (head),
    .count     (skid_cnt)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      beat_q <= '0;
      inflight_q <= 1'b0;
      last_pend_q <= 1'b0;
      desync_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      inflight_q <= inflight_d;
      last_pend_q <= last_pend_d;
      desync_q <= desync_d;
      err_q <= err_d;
    end
  always_comb
    state_d = state_q == IDLE ? (enable ? STREAM : IDLE)
      : state_q == STREAM ? (last_rd ? DRAIN : STREAM)
      : state_q == DRAIN ? (drained ? (enable ? STREAM : IDLE) : DRAIN)
      : IDLE;
  // Skid occupancy plus the read still in flight bounds issue, so a capture never overflows the buffer
  always_comb begin
    lanes_ready = ~|lane_empty;
    lanes_mixed = |lane_empty & ~&lane_empty;
    global_re = state_q == STREAM && lanes_ready && (3'(skid_cnt) + 3'(inflight_q) < 3'd2);
    last_rd = global_re && beat_q == 3'(BEATS - 1);
    feed_valid = skid_cnt != 2'd0;
    feed_data = feed_valid ? head[W-2:0] : '0;
    feed_last = feed_valid && head[W-1];
    pop = feed_valid && feed_ready;
    drained = skid_cnt == 2'd0 && !inflight_q;
    busy = state_q != IDLE;
    desync_err = err_q;
  end
  always_comb begin
    beat_d = state_q != STREAM ? '0 : (global_re && beat_q != 3'(BEATS)) ? beat_q + 3'd1 : beat_q;
    inflight_d = global_re;
    last_pend_d = last_rd;
    desync_d = !lanes_mixed ? '0 : desync_q == DW'(TIMEOUT) ? desync_q : desync_q + 1'b1;
    err_d = err_q || desync_d == DW'(TIMEOUT);
  end
`ifdef ARRAY_FEED_PERF_EN
  logic [31:0] stall_q, stall_d, starve_q, starve_d;
  logic [15:0] burst_q, burst_d;
  always_comb begin
    stall_d = stall_q + 32'(feed_valid && !feed_ready);
    starve_d = starve_q + 32'(state_q == STREAM && !lanes_ready);
    burst_d = burst_q + 16'(pop && head[W-1]);
    stall_cycles = stall_q;
    starve_cycles = starve_q;
    burst_count = burst_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      stall_q <= '0;
      starve_q <= '0;
      burst_q <= '0;
    end else begin
      stall_q <= stall_d;
      starve_q <= starve_d;
      burst_q <= burst_d;
    end
`endif
endmodule

// File: tb/tb_array_feed_scheduler.sv
// tb_array_feed_scheduler: lane FIFO models plus a beat scoreboard exercising bursts, stalls, starvation, desync and reset
module tb_array_feed_scheduler;
  logic clk = 1'b0, resetn = 1'b0, enable = 1'b0, feed_ready = 1'b0;
  logic [3:0] lane_empty;
  logic [3:0] hold = 4'b0;
  logic [31:0] lane_data = '0;
  logic global_re, feed_valid, feed_last, busy, desync_err;
  logic [31:0] feed_data;
`ifdef ARRAY_FEED_PERF_EN
  logic [31:0] stall_cycles, starve_cycles;
  logic [15:0] burst_count;
`endif
  logic [7:0] mem [4][64];
  int wr [4];
  int rd [4];
  logic [32:0] exp_q [$];
  int checks = 0, errors = 0;

  array_feed_scheduler dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .lane_empty (lane_empty),
    .lane_data  (lane_data),
    .global_re  (global_re),
    .feed_data  (feed_data),
    .feed_valid (feed_valid),
    .feed_last  (feed_last),
    .feed_ready (feed_ready),
    .busy       (busy),
    .desync_err (desync_err)
`ifdef ARRAY_FEED_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .starve_cycles (starve_cycles),
    .burst_count   (burst_count)
`endif
  );

  always #5 clk = ~clk;

  // Lane FIFOs with one-cycle read latency
  always @(posedge clk)
    if (global_re)
      for (int i = 0; i < 4; i++) begin
        lane_data[8*i +: 8] <= mem[i][rd[i]];
        rd[i] <= rd[i] + 1;
      end

  always_comb
    for (int i = 0; i < 4; i++) lane_empty[i] = (rd[i] == wr[i]) || hold[i];

  // Lane i word: three zero pads then B(i,j) = base + 16*i + 4*burst + j; expected beats pushed as loaded
  task automatic load(input int nb, input logic [7:0] base);
    for (int k = 0; k < nb; k++) begin
      logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
        mem[i][wr[i]] = (k % 7 < 3) ? 8'h00 : base + 8'(16 * i + 4 * (k / 7) + k % 7 - 3);
        d[8*i +: 8] = mem[i][wr[i]];
        wr[i]++;
      end
      exp_q.push_back({k % 7 == 6, d});
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({global_re, feed_valid, feed_last, busy, desync_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 00000", {global_re, feed_valid, feed_last, busy, desync_err});
    end
    checks++;
    if (feed_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h required 0", feed_data);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || global_re !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b re=%b required 0 0", busy, global_re);
    end
  endtask

  task automatic test_basic;
    int sc = 0, first = -1;
    logic [32:0] e;
    logic [31:0] lastd = '0;
    load(7, 8'hA0);
    feed_ready = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (busy) sc++;
      if (sc == 1) enable = 1'b0;
      if (feed_valid && first < 0) first = sc;
      if (feed_valid && feed_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({feed_last, feed_data} !== e) begin
          errors++;
          $display("FAIL basic_beat got %h required %h", {feed_last, feed_data}, e);
        end
        if (feed_last) lastd = feed_data;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_timeout got %0d beats left required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL basic_latency got %0d required 3", first);
    end
    checks++;
    if (lastd !== 32'hD3C3B3A3) begin
      errors++;
      $display("FAIL basic_last_data got %h required d3c3b3a3", lastd);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || feed_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle busy=%b valid=%b required 0 0", busy, feed_valid);
    end
  endtask

  task automatic test_backpressure;
    int out = 0;
    logic [32:0] e;
    logic [31:0] prev_d = '0;
    logic prev_stall = 1'b0, bad_re = 1'b0, bad_stab = 1'b0;
    load(7, 8'h20);
    enable = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (busy) enable = 1'b0;
      feed_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      if (global_re && out >= 2) bad_re = 1'b1;
      if (prev_stall && (!feed_valid || feed_data !== prev_d)) bad_stab = 1'b1;
      if (feed_valid && feed_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({feed_last, feed_data} !== e) begin
          errors++;
          $display("FAIL bp_beat got %h required %h", {feed_last, feed_data}, e);
        end
      end
      out += int'(global_re) - int'(feed_valid && feed_ready);
      prev_stall = feed_valid && !feed_ready;
      prev_d = feed_data;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout got %0d beats left required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (bad_re) begin
      errors++;
      $display("FAIL bp_read_limit got read with 2 outstanding required none");
    end
    checks++;
    if (bad_stab) begin
      errors++;
      $display("FAIL bp_stable got data change under stall required stable");
    end
    feed_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_starve;
    int sc = 0;
    logic [32:0] e;
    load(7, 8'h40);
    feed_ready = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (busy) sc++;
      if (sc == 1) enable = 1'b0;
      hold[2] = sc >= 3 && sc <= 6;
      #1;
      if (hold[2]) begin
        checks++;
        if (global_re !== 1'b0) begin
          errors++;
          $display("FAIL starve_re cycle %0d got %b required 0", sc, global_re);
        end
      end
      if (sc == 6) begin
        checks++;
        if (feed_valid !== 1'b0) begin
          errors++;
          $display("FAIL starve_valid got %b required 0", feed_valid);
        end
      end
      if (feed_valid && feed_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({feed_last, feed_data} !== e) begin
          errors++;
          $display("FAIL starve_beat got %h required %h", {feed_last, feed_data}, e);
        end
      end
    end
    hold[2] = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL starve_timeout got %0d beats left required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (desync_err !== 1'b0) begin
      errors++;
      $display("FAIL starve_desync got %b required 0", desync_err);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lasts = 0;
    logic started = 1'b0, gap = 1'b0;
    logic [32:0] e;
    load(14, 8'h01);
    feed_ready = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 150 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (busy) started = 1'b1;
      if (started && !busy) gap = 1'b1;
      if (exp_q.size() <= 3) enable = 1'b0;
      if (feed_valid && feed_ready) begin
        e = exp_q.pop_front();
        if (feed_last) lasts++;
        checks++;
        if ({feed_last, feed_data} !== e) begin
          errors++;
          $display("FAIL b2b_beat got %h required %h", {feed_last, feed_data}, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_timeout got %0d beats left required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (lasts != 2) begin
      errors++;
      $display("FAIL b2b_lasts got %0d required 2", lasts);
    end
    checks++;
    if (gap) begin
      errors++;
      $display("FAIL b2b_idle_gap got idle cycle between bursts required none");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end_idle got busy=%b required 0", busy);
    end
  endtask

  task automatic test_desync;
    logic early = 1'b0, rd_seen = 1'b0, dropped = 1'b0;
    logic [32:0] e;
    hold[0] = 1'b1;
    load(7, 8'h08);
    feed_ready = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (busy) enable = 1'b0;
      if (global_re) rd_seen = 1'b1;
      if (k < 15 && desync_err) early = 1'b1;
    end
    checks++;
    if (desync_err !== 1'b1) begin
      errors++;
      $display("FAIL desync_set got %b required 1", desync_err);
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL desync_early got err before cycle 15 required none");
    end
    repeat (5) begin
      @(negedge clk);
      if (global_re) rd_seen = 1'b1;
      if (!desync_err) dropped = 1'b1;
    end
    checks++;
    if (rd_seen) begin
      errors++;
      $display("FAIL desync_read got read while lanes disagree required none");
    end
    hold[0] = 1'b0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (!desync_err) dropped = 1'b1;
      if (feed_valid && feed_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({feed_last, feed_data} !== e) begin
          errors++;
          $display("FAIL desync_beat got %h required %h", {feed_last, feed_data}, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL desync_timeout got %0d beats left required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (dropped) begin
      errors++;
      $display("FAIL desync_sticky got err cleared without reset required held");
    end
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (desync_err !== 1'b0) begin
      errors++;
      $display("FAIL desync_reset got %b required 0", desync_err);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int n = 0;
    logic resumed = 1'b0;
    load(7, 8'h60);
    feed_ready = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (busy) enable = 1'b0;
      if (feed_valid && feed_ready) n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL midrst_timeout got %0d beats required 4", n);
    end
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({global_re, feed_valid, feed_last, busy, desync_err} !== 5'b0 || feed_data !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outputs got %b/%h required 00000/0", {global_re, feed_valid, feed_last, busy, desync_err}, feed_data);
    end
`ifdef ARRAY_FEED_PERF_EN
    checks++;
    if (stall_cycles !== 32'h0) begin
      errors++;
      $display("FAIL midrst_stall got %0d required 0", stall_cycles);
    end
`endif
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (feed_valid || busy) resumed = 1'b1;
    end
    checks++;
    if (resumed) begin
      errors++;
      $display("FAIL midrst_resume got activity after reset required idle");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_starve;
    test_back_to_back;
    test_desync;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
